// File: rtl/player_turn_controller_pkg.sv
// Shared types, constants and card arithmetic for the player turn controller.
package player_turn_controller_pkg;

    typedef enum logic [1:0] {
        COMMAND_NONE  = 2'd0,
        COMMAND_HIT   = 2'd1,
        COMMAND_STAND = 2'd2
    } gameCommand;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CMD,
        WAIT_RELEASE,
        REQ_CARD,
        EVAL,
        DONE
    } turnState;

    localparam logic [4:0] BLACKJACK_LIMIT = 5'd21;
    localparam logic [4:0] FACE_VALUE      = 5'd10;
    localparam logic [4:0] SOFT_ACE_BONUS  = 5'd10;

    function automatic logic rank_ok(input logic [3:0] rank);
        return (rank >= 4'd1) && (rank <= 4'd13);
    endfunction

    function automatic logic [4:0] card_value(input logic [3:0] rank);
        return (rank > 4'd10) ? FACE_VALUE : {1'b0, rank};
    endfunction

    // One ace may count 11 only while that keeps the hand at or below 21.
    function automatic logic [4:0] soft_total(input logic [4:0] hard, input logic ace);
        return (ace && (hard <= (BLACKJACK_LIMIT - SOFT_ACE_BONUS))) ? hard + SOFT_ACE_BONUS : hard;
    endfunction

endpackage

// File: rtl/player_turn_controller_if.sv
// Command/card/result bundle between the input block, deck logic, game FSM and the controller.
interface player_turn_controller_if;
    import player_turn_controller_pkg::*;

    logic       start_turn;
    logic       ready;
    gameCommand command;
    logic       card_valid;
    logic [3:0] card_rank;
    logic       turnIndicator;
    logic       card_req;
    logic [4:0] hand_total;
    logic [3:0] card_count;
    logic       bust;
    logic       stood;
    logic       turn_done;

    modport master (
        output start_turn, ready, command, card_valid, card_rank,
        input  turnIndicator, card_req, hand_total, card_count, bust, stood, turn_done
    );

    modport slave (
        input  start_turn, ready, command, card_valid, card_rank,
        output turnIndicator, card_req, hand_total, card_count, bust, stood, turn_done
    );
endinterface

// File: rtl/player_turn_controller_press_debouncer.sv
// Fires on the CYCLES-th consecutive cycle that i_en is high; any low cycle restarts the count.
module press_debouncer #(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    output logic o_done
);
    localparam int unsigned   CW   = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] r_cnt;

    assign o_done = i_en && (r_cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)             r_cnt <= '0;
        else if (!i_en || o_done) r_cnt <= '0;
        else                      r_cnt <= r_cnt + CW'(1);
    end
endmodule

// File: rtl/player_turn_controller.sv
// Player turn FSM: debounced HIT/STAND handling, card requests and soft-ace hand totals.
module player_turn_controller
    import player_turn_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    player_turn_controller_if.slave  bus
);
    turnState   r_state;
    gameCommand r_prev_cmd;
    logic [4:0] r_hard;
    logic       r_ace;
    logic       r_turn_ind, r_card_req, r_bust, r_stood, r_turn_done;
    logic [4:0] r_hand_total;
    logic [3:0] r_card_count;

    logic       w_press_en, w_press_done, w_rel_en, w_rel_done, w_accept, w_ace_nxt;
    logic [4:0] w_hard_nxt;

    // A press only counts while the same non-idle command repeats cycle to cycle.
    assign w_press_en = (r_state == WAIT_CMD) && bus.ready && (bus.command != COMMAND_NONE)
                        && (bus.command == r_prev_cmd);
    assign w_rel_en   = (r_state == WAIT_RELEASE) && !bus.ready;
    assign w_accept   = (r_state == REQ_CARD) && r_card_req && bus.card_valid && rank_ok(bus.card_rank);
    assign w_hard_nxt = r_hard + card_value(bus.card_rank);
    assign w_ace_nxt  = r_ace || (bus.card_rank == 4'd1);

    press_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_press_db (
        .clk(clk), .reset_n(reset_n), .i_en(w_press_en), .o_done(w_press_done));

    press_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_release_db (
        .clk(clk), .reset_n(reset_n), .i_en(w_rel_en), .o_done(w_rel_done));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_prev_cmd   <= COMMAND_NONE;
            r_hard       <= '0;
            r_ace        <= 1'b0;
            r_turn_ind   <= 1'b0;
            r_card_req   <= 1'b0;
            r_hand_total <= '0;
            r_card_count <= '0;
            r_bust       <= 1'b0;
            r_stood      <= 1'b0;
            r_turn_done  <= 1'b0;
        end else begin
            r_prev_cmd  <= bus.command;
            r_turn_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start_turn) begin
                    r_hard       <= '0;
                    r_ace        <= 1'b0;
                    r_hand_total <= '0;
                    r_card_count <= '0;
                    r_bust       <= 1'b0;
                    r_stood      <= 1'b0;
                    r_turn_ind   <= 1'b1;
                    r_state      <= WAIT_CMD;
                end
                WAIT_CMD: if (w_press_done) begin
                    r_turn_ind <= 1'b0;
                    if (bus.command == COMMAND_HIT) begin
                        r_state <= REQ_CARD;
                    end else begin
                        r_stood     <= 1'b1;
                        r_turn_done <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                REQ_CARD: begin
                    if (w_accept) begin
                        r_card_req   <= 1'b0;
                        r_hard       <= w_hard_nxt;
                        r_ace        <= w_ace_nxt;
                        r_hand_total <= soft_total(w_hard_nxt, w_ace_nxt);
                        if (r_card_count != 4'd15) r_card_count <= r_card_count + 4'd1;
                        r_state      <= EVAL;
                    end else begin
                        r_card_req <= 1'b1;
                    end
                end
                EVAL: begin
                    if (r_hard > BLACKJACK_LIMIT) begin
                        r_bust      <= 1'b1;
                        r_turn_done <= 1'b1;
                        r_state     <= DONE;
                    end else if (soft_total(r_hard, r_ace) == BLACKJACK_LIMIT) begin
                        r_stood     <= 1'b1;
                        r_turn_done <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_turn_ind <= 1'b1;
                        r_state    <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: if (w_rel_done) r_state <= WAIT_CMD;
                DONE:         r_state <= IDLE;
                default:      r_state <= IDLE;
            endcase
        end
    end

    assign bus.turnIndicator = r_turn_ind;
    assign bus.card_req      = r_card_req;
    assign bus.hand_total    = r_hand_total;
    assign bus.card_count    = r_card_count;
    assign bus.bust          = r_bust;
    assign bus.stood         = r_stood;
    assign bus.turn_done     = r_turn_done;
endmodule

// File: tb/tb_player_turn_controller.sv
// Scoreboard bench: driver pushes blackjack-rule expectations, monitor checks card accepts and turn ends.
module tb_player_turn_controller;
    import player_turn_controller_pkg::*;

    localparam int DEB = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    player_turn_controller_if bus();

    player_turn_controller #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int total;
        int count;
        bit bust;
        bit stood;
    } exp_t;

    exp_t sb[$];
    int   hand[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Blackjack scoring straight from the card list.
    function automatic exp_t model(input bit is_done);
        exp_t r;
        int   hard = 0;
        bit   ace  = 0;
        foreach (hand[i]) begin
            hard += (hand[i] > 10) ? 10 : hand[i];
            if (hand[i] == 1) ace = 1;
        end
        r.is_done = is_done;
        r.total   = (ace && hard + 10 <= 21) ? hard + 10 : hard;
        r.count   = (hand.size() > 15) ? 15 : hand.size();
        r.bust    = hard > 21;
        r.stood   = is_done && hard <= 21;
        return r;
    endfunction

    function automatic int outs();
        return int'({bus.turnIndicator, bus.card_req, bus.hand_total, bus.card_count,
                     bus.bust, bus.stood, bus.turn_done});
    endfunction

    task automatic release_key();
        bus.ready   = 1'b0;
        bus.command = COMMAND_NONE;
        repeat (DEB + 3) tick();
    endtask

    task automatic begin_turn();
        hand.delete();
        bus.start_turn = 1'b1;
        tick();
        bus.start_turn = 1'b0;
    endtask

    task automatic press_until_req(output int n);
        bus.ready   = 1'b1;
        bus.command = COMMAND_HIT;
        n = 0;
        while (bus.card_req !== 1'b1 && n < 4 * DEB) begin
            tick();
            n++;
        end
        check("card_req_rises", int'(bus.card_req), 1);
    endtask

    // First press cycle has no matching predecessor, so card_req appears DEB+2 cycles after it.
    task automatic hit_card(input int rank, input bit bad_first, input bit chk_lat, output bit ended);
        int   n;
        int   b;
        exp_t e;
        press_until_req(n);
        if (chk_lat) check("press_to_req_cycles", n, DEB + 2);
        if (bad_first) begin
            b = $urandom_range(0, 2);
            bus.card_valid = 1'b1;
            bus.card_rank  = (b == 0) ? 4'd0 : (b == 1) ? 4'd14 : 4'd15;
            tick();
            check("bad_rank_req_held", int'(bus.card_req), 1);
            bus.card_valid = 1'b0;
        end
        repeat ($urandom_range(0, 3)) tick();
        hand.push_back(rank);
        e = model(0);
        sb.push_back(e);
        ended = e.bust || (e.total == 21);
        if (ended) sb.push_back(model(1));
        bus.card_valid = 1'b1;
        bus.card_rank  = 4'(rank);
        tick();
        bus.card_valid = 1'b0;
        bus.card_rank  = 4'($urandom);
        tick();
        tick();
    endtask

    task automatic hit(input int rank);
        bit ended;
        hit_card(rank, 1'b0, 1'b0, ended);
        release_key();
    endtask

    task automatic stand_turn();
        int n = 0;
        sb.push_back(model(1));
        bus.ready   = 1'b1;
        bus.command = COMMAND_STAND;
        while (bus.turnIndicator === 1'b1 && n < 4 * DEB) begin
            tick();
            n++;
        end
        check("stand_ends_turn", int'(bus.turnIndicator), 0);
        release_key();
    endtask

    task automatic short_press(input int len);
        bit seen = 0;
        bus.ready   = 1'b1;
        bus.command = COMMAND_HIT;
        repeat (len) begin
            tick();
            if (bus.card_req) seen = 1;
        end
        bus.ready   = 1'b0;
        bus.command = COMMAND_NONE;
        repeat (DEB + 3) begin
            tick();
            if (bus.card_req) seen = 1;
        end
        check("short_press_no_req", int'(seen), 0);
        check("short_press_still_waiting", int'(bus.turnIndicator), 1);
    endtask

    task automatic hold_key(input int cycles);
        bit seen = 0;
        bus.ready   = 1'b1;
        bus.command = COMMAND_HIT;
        repeat (cycles) begin
            bus.card_valid = 1'($urandom_range(0, 1));
            bus.card_rank  = 4'($urandom_range(1, 13));
            tick();
            if (bus.card_req) seen = 1;
        end
        bus.card_valid = 1'b0;
        check("held_key_no_second_req", int'(seen), 0);
        check("held_key_count", int'(bus.card_count), model(0).count);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && bus.card_req && bus.card_valid && bus.card_rank >= 4'd1 && bus.card_rank <= 4'd13) begin
                check("sb_card_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sb_card_order", int'(e.is_done), 0);
                    @(negedge clk);
                    check("hand_total", int'(bus.hand_total), e.total);
                    check("card_count", int'(bus.card_count), e.count);
                end
            end else if (reset_n && bus.turn_done) begin
                check("sb_done_expected", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sb_done_order", int'(e.is_done), 1);
                    check("done_hand_total", int'(bus.hand_total), e.total);
                    check("done_card_count", int'(bus.card_count), e.count);
                    check("done_bust", int'(bus.bust), int'(e.bust));
                    check("done_stood", int'(bus.stood), int'(e.stood));
                    @(negedge clk);
                    check("turn_done_one_cycle", int'(bus.turn_done), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit   ended;
        int   n;
        exp_t e;
        bus.start_turn = 1'b0;
        bus.ready      = 1'b0;
        bus.command    = COMMAND_NONE;
        bus.card_valid = 1'b0;
        bus.card_rank  = 4'd0;
        repeat (3) tick();
        check("reset_outputs", outs(), 0);
        reset_n = 1'b1;
        tick();

        // King, then a key held far past the debounce window, then stand.
        begin_turn();
        hit_card(13, 1'b0, 1'b1, ended);
        hold_key(100);
        release_key();
        stand_turn();

        // One-short press, ignored start_turn, soft ace demoted by a ten.
        begin_turn();
        short_press(DEB);
        hit(1);
        bus.start_turn = 1'b1;
        tick();
        bus.start_turn = 1'b0;
        tick();
        check("start_ignored_indicator", int'(bus.turnIndicator), 1);
        check("start_ignored_count", int'(bus.card_count), 1);
        hit(5);
        hit(10);
        stand_turn();

        // Bust at 25.
        begin_turn();
        hit(10);
        hit(6);
        hit(9);
        check("bust_held_total", int'(bus.hand_total), 25);
        check("bust_held_flag", int'(bus.bust), 1);

        // Ace + king auto-stands at 21.
        begin_turn();
        hit(1);
        hit(13);

        // Invalid rank discarded before a real card.
        begin_turn();
        hit_card(7, 1'b1, 1'b0, ended);
        release_key();
        stand_turn();

        // Stand with no cards.
        begin_turn();
        stand_turn();

        // Sixteen cards under 22 to saturate the card counter.
        begin_turn();
        repeat (10) hit(1);
        hit(2);
        repeat (5) hit(1);
        stand_turn();

        // Async reset while a card request is outstanding.
        begin_turn();
        hit(9);
        press_until_req(n);
        #2 reset_n = 1'b0;
        #1 check("async_reset_mid_req", outs(), 0);
        bus.ready   = 1'b0;
        bus.command = COMMAND_NONE;
        tick();
        reset_n = 1'b1;
        hand.delete();
        repeat (4) tick();
        check("idle_after_reset", int'(bus.turnIndicator), 0);

        for (int t = 0; t < 8; t++) begin
            begin_turn();
            ended = 0;
            for (int k = 0; k < 8 && !ended; k++) begin
                e = model(0);
                if (k > 0 && ($urandom_range(0, 3) == 0 || e.total >= 18)) begin
                    stand_turn();
                    ended = 1;
                end else begin
                    if ($urandom_range(0, 3) == 0) short_press($urandom_range(1, DEB));
                    hit_card($urandom_range(1, 13), $urandom_range(0, 3) == 0, 1'b1, ended);
                    release_key();
                end
            end
            if (!ended) stand_turn();
        end

        repeat (8) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/player_turn_controller.md
Name: player_turn_controller

Overview:
- Consumer end of the player command interface: drives `turnIndicator` to the input block and accepts its `ready`/`command` pair.
- Debounces each button press, executes it exactly once (HIT → request a card from the dealer/deck logic, STAND → end turn), then waits for release before the next press.
- Tracks the player's hand total with soft-ace handling and reports bust, stand and a turn-complete pulse to the game FSM.

Parameters:
- `DEBOUNCE_CYCLES`, 16, consecutive cycles a press (or a release) must be stable before it is acted on; must be ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_turn`  in  1  one-cycle pulse from the game FSM; starts a new turn.
- `ready`  in  1  from the input block: it is our turn and a key is down.
- `command`  in  gameCommand  from the input block: `COMMAND_NONE`, `COMMAND_HIT` or `COMMAND_STAND`.
- `card_valid`  in  1  deck logic presents a card on `card_rank`.
- `card_rank`  in  4  card rank: 1 = ace, 2–10 = pips, 11–13 = J/Q/K.
- `turnIndicator`  out  1  high while the player may enter commands.
- `card_req`  out  1  request one card from the deck logic.
- `hand_total`  out  5  effective hand value, aces counted soft where legal.
- `card_count`  out  4  cards received this turn; saturates at 15.
- `bust`  out  1  hand exceeded 21; held until the next `start_turn`.
- `stood`  out  1  turn ended without bust; held until the next `start_turn`.
- `turn_done`  out  1  one-cycle pulse when the turn ends.

Behaviour:
- Reset (async, `reset_n` = 0): state IDLE. All outputs 0: `turnIndicator`, `card_req`, `hand_total`, `card_count`, `bust`, `stood`, `turn_done`. Internal hard sum, ace flag and debounce counter cleared. Reset mid-turn abandons the turn; no `turn_done` is issued.
- States: IDLE, WAIT_CMD, WAIT_RELEASE, REQ_CARD, EVAL, DONE.
- IDLE
  - `start_turn` = 1 → clear hard sum, ace flag, `card_count`, `bust`, `stood`; go to WAIT_CMD.
  - `start_turn` is ignored in all other states.
- WAIT_CMD (`turnIndicator` = 1)
  - The debounce counter increments each cycle that `ready` = 1 and `command` equals the previous cycle's `command` and is not `COMMAND_NONE`.
  - Any other cycle resets the counter to 0.
  - When the counter reaches `DEBOUNCE_CYCLES`: HIT → REQ_CARD; STAND → set `stood`, go to DONE.
  - If HIT and STAND alternate, the press is never accepted.
- REQ_CARD
  - `card_req` = 1 from the cycle after entry and held until the cycle where `card_req` && `card_valid`; the card is accepted that cycle.
  - `card_req` drops the next cycle.
  - Rank 1–13 accepted: add min(rank, 10) to the hard sum; set ace flag if rank = 1; increment `card_count` (saturate 15); go to EVAL.
  - Rank 0, 14 or 15: discarded, `card_req` stays high.
  - `card_valid` while `card_req` = 0 is ignored.
  - `turnIndicator` is 0 in this state.
- EVAL (1 cycle)
  - Effective total = hard sum + 10 if ace flag && hard sum ≤ 11, else hard sum.
  - `hand_total` is updated with the effective total on the EVAL cycle.
  - Hard sum > 21 → set `bust`, go to DONE.
  - Effective total = 21 → set `stood` (automatic stand), go to DONE.
  - Otherwise → WAIT_RELEASE.
- WAIT_RELEASE (`turnIndicator` = 1)
  - Count consecutive cycles with `ready` = 0.
  - After `DEBOUNCE_CYCLES` → WAIT_CMD with the counter cleared.
  - Any `ready` = 1 during the count resets it, so a held HIT key never produces a second card.
- DONE: `turn_done` = 1 for exactly this cycle, then IDLE. `hand_total`, `card_count`, `bust`, `stood` hold until the next `start_turn`.
- Width: hard sum is at most 21 + 10 = 31 before the bust check, so 5 bits never overflow.
- Latency:
  - Stable press to `card_req` high: `DEBOUNCE_CYCLES` + 1 cycles.
  - Card accept to `hand_total` update: 1 cycle.

Decomposition:
- `gameCommand` typedef stays in the shared `gameCommand.svh`.
- Add to the shared package:
  - the state enum (`turnState`);
  - constants `BLACKJACK_LIMIT` = 21, `FACE_VALUE` = 10, `SOFT_ACE_BONUS` = 10.
- One natural sub-module: `press_debouncer`, a generic stable-for-N-cycles detector reused for both the press and release counts.

Test Plan:
- Reset mid-REQ_CARD with `card_req` = 1 → all outputs 0 asynchronously; IDLE; no `turn_done`.
- `start_turn`; HIT held 16 cycles; card rank 13 with `card_valid` → `card_req` asserted cycle 17 and dropped after the accept; `hand_total` = 10; `card_count` = 1. Key held 100 more cycles → no second `card_req`.
- HIT pressed only 15 cycles, then released → no `card_req`; state remains WAIT_CMD.
- Cards 1, then 5 (release between presses) → `hand_total` 11, then 16. Third card 10 → hard sum 16, `hand_total` = 16, no bust (ace demoted to hard).
- Cards 10, 6, 9 → hard sum 25; `bust` = 1; `turn_done` pulses exactly 1 cycle; `hand_total` = 25 held.
- Cards 1, 13 → `hand_total` = 21, `stood` = 1 automatic stand.
- Card rank 0 presented first → discarded, `card_req` stays high.
- STAND with 0 cards → `stood` = 1, `hand_total` = 0, `turn_done` pulse.
- `start_turn` during WAIT_CMD → ignored.
